// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the fetch controller and the PC sequencer.
// The controller drives redirects and halts. The sequencer reports the PC and the return-stack state.
interface pc_sequencer_if #(
    parameter int INST_ADDR_WIDTH = 16,
    parameter int RAS_DEPTH       = 4
);
    logic                               halt;
    logic                               resume;
    logic                               stall;
    logic                               trap;
    logic                               pc_src;
    logic                               call;
    logic                               ret;
    logic [INST_ADDR_WIDTH-1:0]         branch_addr;
    logic                               clr_flags;

    logic [INST_ADDR_WIDTH-1:0]         pc;
    logic [INST_ADDR_WIDTH-1:0]         pc_next;
    logic [INST_ADDR_WIDTH-1:0]         epc;
    logic                               halted;
    logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count;
    logic                               ras_overflow;
    logic                               ras_underflow;
    logic                               proto_err;

    modport master (
        output halt, resume, stall, trap, pc_src, call, ret, branch_addr, clr_flags,
        input  pc, pc_next, epc, halted, ras_count, ras_overflow, ras_underflow, proto_err
    );

    modport slave (
        input  halt, resume, stall, trap, pc_src, call, ret, branch_addr, clr_flags,
        output pc, pc_next, epc, halted, ras_count, ras_overflow, ras_underflow, proto_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Registered fetch-stage program counter with halt/resume, stall, trap and a circular
// return-address stack. pc_next exposes the value pc loads at the next edge, for prefetch.
module pc_sequencer #(
    parameter int                         INST_ADDR_WIDTH   = 16,
    parameter int                         NUM_BYTES_IN_INST = 2,
    parameter int                         RAS_DEPTH         = 4,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR      = '0,
    parameter logic [INST_ADDR_WIDTH-1:0] TRAP_VECTOR       = INST_ADDR_WIDTH'('h0010)
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [INST_ADDR_WIDTH-1:0] INC  = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
    localparam logic [CNT_W-1:0]           FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_ADDR_WIDTH-1:0] epc_q, epc_d;
    logic [INST_ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]           top_ptr_q;
    logic [PTR_W-1:0]           push_ptr;
    logic [CNT_W-1:0]           count_q;
    logic                       push, pop;
    logic                       ras_full, ras_empty;
    logic                       overflow_q, underflow_q, proto_err_q;
    logic                       overflow_set, underflow_set, proto_err_set;
    logic                       multi_redirect;

    assign push_ptr       = top_ptr_q + PTR_W'(1);
    assign ras_full       = (count_q == FULL);
    assign ras_empty      = (count_q == '0);
    assign multi_redirect = (bus.call & bus.ret) | (bus.call & bus.pc_src) | (bus.ret & bus.pc_src);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        epc_d         = epc_q;
        push          = 1'b0;
        pop           = 1'b0;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        proto_err_set = 1'b0;

        if (bus.trap) begin
            pc_d    = TRAP_VECTOR;
            epc_d   = pc_q;
            state_d = RUN;
        end else if (state_q == HALTED || bus.halt) begin
            // A halt asserted together with resume keeps the sequencer halted.
            if (bus.halt) begin
                state_d = HALTED;
            end else if (bus.resume) begin
                state_d = RUN;
            end
        end else if (!bus.stall) begin
            proto_err_set = multi_redirect;
            if (bus.ret) begin
                if (!ras_empty) begin
                    pc_d = ras_mem[top_ptr_q];
                    pop  = 1'b1;
                end else begin
                    pc_d          = TRAP_VECTOR;
                    epc_d         = pc_q;
                    underflow_set = 1'b1;
                end
            end else if (bus.call) begin
                push         = 1'b1;
                overflow_set = ras_full;
                pc_d         = bus.branch_addr;
            end else if (bus.pc_src) begin
                pc_d = bus.branch_addr;
            end else begin
                pc_d = pc_q + INC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    // On a push into a full stack, the write lands on the oldest slot, and the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_ptr_q <= '0;
            count_q   <= '0;
        end else if (push) begin
            top_ptr_q <= push_ptr;
            if (!ras_full) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (pop) begin
            top_ptr_q <= top_ptr_q - PTR_W'(1);
            count_q   <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[push_ptr] <= pc_q + INC;
        end
    end

    // A new error in the same cycle as clr_flags leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_set  | (overflow_q  & ~bus.clr_flags);
            underflow_q <= underflow_set | (underflow_q & ~bus.clr_flags);
            proto_err_q <= proto_err_set | (proto_err_q & ~bus.clr_flags);
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_next       = pc_d;
    assign bus.epc           = epc_q;
    assign bus.halted        = (state_q == HALTED);
    assign bus.ras_count     = count_q;
    assign bus.ras_overflow  = overflow_q;
    assign bus.ras_underflow = underflow_q;
    assign bus.proto_err     = proto_err_q;

endmodule
